maxnet_result_writer: RTL and testbench

Sink-side counterpart to the weight/input memory in the Maxnet datapath. It accepts 32-bit IEEE-754 activations one word per cycle over a valid/ready handshake and writes them into a DEPTH-entry vector buffer. After each full vector it checks for convergence: exactly one strictly positive entry. It then either reports the winner or signals the controller to run another iteration, with an iteration cap.

---
 rtl/maxnet_result_writer_if.sv | 8 +
 rtl/maxnet_result_writer.sv | 96 +++++++++
 tb/tb_maxnet_result_writer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/maxnet_result_writer_if.sv
// maxnet_result_writer_if: valid/ready word stream into the Maxnet result writer.
interface maxnet_result_writer_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  modport master (output in_valid, output in_data, input in_ready);
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/maxnet_result_writer.sv
// maxnet_result_writer: collects Maxnet activation vectors and flags convergence, iteration or failure.
module maxnet_result_writer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int MAX_ITER = 16,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  maxnet_result_writer_if.slave  s,
  output logic [DEPTH*WIDTH-1:0] x_flat,
  output logic                   iter_valid,
  output logic [7:0]             iter_count,
  output logic                   done,
  output logic                   fail,
  output logic [IW-1:0]          winner_idx,
  output logic [WIDTH-1:0]       winner_val
);
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DONE, FAIL} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0] wr_ptr, pos_idx;
  logic [CW-1:0] pos_cnt;
  logic acc, last, cap, idle_like;
  assign s.in_ready = state == COLLECT;
  assign acc = s.in_valid && s.in_ready;
  assign last = wr_ptr == IW'(DEPTH - 1);
  assign cap = ({1'b0, iter_count} + 9'd1) == 9'(MAX_ITER);
  assign idle_like = state == IDLE || state == DONE || state == FAIL;
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign x_flat[g*WIDTH +: WIDTH] = mem[g];
  end
  // -0.0 has a clear magnitude, so only the sign-clear nonzero words count
  always_comb begin
    pos_cnt = '0;
    pos_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!mem[i][WIDTH-1] && |mem[i][WIDTH-2:0]) begin
        pos_cnt = pos_cnt + CW'(1);
        pos_idx = IW'(i);
      end
    end
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, FAIL: nxt = start ? COLLECT : state;
      COLLECT: nxt = acc && last ? CHECK : COLLECT;
      CHECK: nxt = pos_cnt == CW'(1) ? DONE : (pos_cnt == '0 || cap) ? FAIL : COLLECT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      iter_valid <= 1'b0;
      iter_count <= '0;
      done <= 1'b0;
      fail <= 1'b0;
      winner_idx <= '0;
      winner_val <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      iter_valid <= 1'b0;
      if (idle_like && start) begin
        wr_ptr <= '0;
        iter_count <= '0;
        done <= 1'b0;
        fail <= 1'b0;
        winner_idx <= '0;
        winner_val <= '0;
      end
      if (acc) begin
        mem[wr_ptr] <= s.in_data;
        wr_ptr <= last ? '0 : wr_ptr + IW'(1);
      end
      if (state == CHECK) begin
        if (pos_cnt == CW'(1)) begin
          done <= 1'b1;
          winner_idx <= pos_idx;
          winner_val <= mem[pos_idx];
        end else if (pos_cnt == '0) begin
          fail <= 1'b1;
        end else begin
          iter_count <= iter_count + 8'd1;
          fail <= cap;
          iter_valid <= !cap;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxnet_result_writer.sv
// tb_maxnet_result_writer: directed and randomized vectors checked against a behavioural Maxnet convergence model.
module tb_maxnet_result_writer;
  localparam int MI = 3;
  typedef logic [31:0] vec_t [4];
  logic clk = 0, rst_n = 0, start = 0;
  logic [127:0] x_flat;
  logic iter_valid, done, fail;
  logic [7:0] iter_count;
  logic [1:0] winner_idx;
  logic [31:0] winner_val;
  int checks = 0, errors = 0, ref_iter = 0;
  bit term;
  maxnet_result_writer_if #(.WIDTH(32)) bus ();
  maxnet_result_writer #(.WIDTH(32), .DEPTH(4), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(bus), .x_flat(x_flat),
    .iter_valid(iter_valid), .iter_count(iter_count), .done(done), .fail(fail),
    .winner_idx(winner_idx), .winner_val(winner_val));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_run();
    start = 1;
    tick();
    start = 0;
    ref_iter = 0;
    chk("start_ready", bus.in_ready, 1);
    chk("start_done", {done, fail, iter_count}, 0);
  endtask
  task automatic send(input logic [31:0] w, input int p_valid, input bit rs);
    int n = 0;
    bit acc = 0;
    while (!acc && n < 200) begin
      bus.in_valid = $urandom_range(99) < p_valid;
      bus.in_data = bus.in_valid ? w : $urandom;
      start = rs ? 1'($urandom_range(1)) : 1'b0;
      acc = bus.in_valid && bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 0;
    start = 0;
    chk("accept", acc, 1);
  endtask
  task automatic send_vec(input vec_t v, input int p_valid, input bit rs, output bit terminal);
    int pc = 0, widx = 0;
    bit exp_done, exp_fail, exp_iter;
    for (int i = 0; i < 4; i++) send(v[i], p_valid, rs);
    chk("check_ready", bus.in_ready, 0);
    tick();
    for (int i = 0; i < 4; i++)
      if (v[i][31] == 1'b0 && v[i][30:0] != 0) begin
        pc++;
        widx = i;
      end
    if (pc > 1) ref_iter++;
    exp_done = pc == 1;
    exp_fail = pc == 0 || (pc > 1 && ref_iter == MI);
    exp_iter = pc > 1 && ref_iter < MI;
    chk("done", done, exp_done);
    chk("fail", fail, exp_fail);
    chk("iter_valid", iter_valid, exp_iter);
    chk("iter_count", iter_count, ref_iter);
    chk("winner_idx", winner_idx, exp_done ? widx : 0);
    chk("winner_val", winner_val, exp_done ? v[widx] : 0);
    chk("x_flat", x_flat, {v[3], v[2], v[1], v[0]});
    chk("ready_after", bus.in_ready, exp_iter);
    terminal = !exp_iter;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hbe4c_cccd;
      3: return 32'h3f80_0000;
      4: return {1'b0, 31'($urandom_range(32'h7fff_ffff, 1))};
      default: return {1'b1, 31'($urandom_range(32'h7fff_ffff, 1))};
    endcase
  endfunction
  initial begin
    vec_t v;
    bus.in_valid = 0;
    bus.in_data = 0;
    #12;
    chk("rst_outputs", {iter_valid, done, fail, iter_count, winner_idx, winner_val}, 0);
    chk("rst_xflat", x_flat, 0);
    chk("rst_ready", bus.in_ready, 0);
    rst_n = 1;
    tick();
    chk("idle_ready", bus.in_ready, 0);
    start_run();
    v = '{32'h0, 32'h3f80_0000, 32'h8000_0000, 32'h0};
    send_vec(v, 100, 0, term);
    start_run();
    v = '{32'h3f80_0000, 32'h3e4c_cccd, 32'h0, 32'h0};
    send_vec(v, 100, 0, term);
    v = '{32'h3f19_999a, 32'h0, 32'h0, 32'h0};
    send_vec(v, 100, 0, term);
    start_run();
    v = '{32'h8000_0000, 32'h0, 32'h0, 32'h8000_0000};
    send_vec(v, 100, 0, term);
    start_run();
    v = '{32'h3f80_0000, 32'h3f80_0000, 32'h0, 32'h0};
    for (int k = 0; k < MI; k++) send_vec(v, 100, 0, term);
    tick();
    tick();
    chk("fail_held", {fail, iter_count, bus.in_ready, iter_valid}, {1'b1, 8'(MI), 1'b0, 1'b0});
    for (int r = 0; r < 8; r++) begin
      start_run();
      term = 0;
      while (!term) begin
        for (int i = 0; i < 4; i++) v[i] = pick();
        if (r == 0) v[2] = 32'hbe4c_cccd;
        send_vec(v, 50, 1, term);
      end
    end
    start_run();
    send(32'h3f80_0000, 100, 0);
    send(32'h4000_0000, 100, 0);
    rst_n = 0;
    #1;
    chk("midrst_outputs", {iter_valid, done, fail, iter_count, winner_idx, winner_val}, 0);
    chk("midrst_xflat", x_flat, 0);
    chk("midrst_ready", bus.in_ready, 0);
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("post_rst_ready", bus.in_ready, 0);
    start_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
